// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline with memory-wait watchdog
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1_d,
  input  logic [4:0]  rs2_d,
  input  logic        rs1_used_d,
  input  logic        rs2_used_d,
  input  logic [4:0]  rd_e,
  input  logic        mem_read_e,
  input  logic        branch_taken_e,
  input  logic        dm_req_m,
  input  logic        dm_ready_m,
  output logic        en_f,
  output logic        en_d,
  output logic        en_e,
  output logic        en_m,
  output logic        en_w,
  output logic        flush_d,
  output logic        flush_e,
  output logic        flush_w,
  output logic        dm_timeout,
  output logic [1:0]  state,
  output logic [15:0] stall_cycles
);
  typedef enum logic [1:0] {RUN = 2'b00, MEM_WAIT = 2'b01, HALT = 2'b10} state_t;
  state_t state_q, state_n;
  logic [CNT_W-1:0] wait_cnt, wait_n;
  logic tmo_n, miss, lu, halt, freeze, lu_stall, last;
  assign miss = dm_req_m & ~dm_ready_m;
  assign lu = mem_read_e & (rd_e != 5'd0) &
              ((rs1_used_d & (rs1_d == rd_e)) | (rs2_used_d & (rs2_d == rd_e)));
  assign halt = state_q == HALT;
  assign freeze = miss & ~halt;
  assign lu_stall = lu & ~branch_taken_e;
  assign last = (wait_cnt + CNT_W'(1)) == CNT_W'(MEM_TIMEOUT);
  assign state = state_q;
  // state, wait counter and sticky watchdog flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      wait_cnt <= '0;
      dm_timeout <= 1'b0;
    end else begin
      state_q <= state_n;
      wait_cnt <= wait_n;
      dm_timeout <= tmo_n;
    end
  end
  // next state: a miss freezes the pipe until ready or the watchdog trips
  always_comb begin
    state_n = state_q;
    wait_n = wait_cnt;
    tmo_n = dm_timeout;
    case (state_q)
      RUN: if (miss) begin
        wait_n = CNT_W'(1);
        state_n = (MEM_TIMEOUT == 1) ? HALT : MEM_WAIT;
        tmo_n = dm_timeout | (MEM_TIMEOUT == 1);
      end
      MEM_WAIT: begin
        state_n = !miss ? RUN : last ? HALT : MEM_WAIT;
        wait_n = !miss ? '0 : last ? wait_cnt : wait_cnt + CNT_W'(1);
        tmo_n = dm_timeout | (miss & last);
      end
      default: state_n = HALT;
    endcase
  end
  // enables and flushes; reset forces every register to hold a bubble
  always_comb begin
    en_f = ~rst & ~halt & ~freeze & ~lu_stall;
    en_d = ~rst & ~halt & ~freeze & ~lu_stall;
    en_e = ~rst & ~halt & ~freeze;
    en_m = ~rst & ~halt & ~freeze;
    en_w = ~rst & ~halt;
    flush_d = rst | (~halt & ~freeze & branch_taken_e);
    flush_e = rst | (~halt & ~freeze & (branch_taken_e | lu));
    flush_w = rst | halt | freeze;
  end
  // saturating count of cycles where fetch is stalled outside HALT
  always_ff @(posedge clk) begin
    if (rst) stall_cycles <= '0;
    else if (~en_f & ~halt & (stall_cycles != 16'hFFFF)) stall_cycles <= stall_cycles + 16'd1;
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: vector table plus multi-cycle sequences against pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] rs1_d, rs2_d, rd_e;
  logic rs1_used_d, rs2_used_d, mem_read_e, branch_taken_e, dm_req_m, dm_ready_m;
  logic en_f, en_d, en_e, en_m, en_w, flush_d, flush_e, flush_w, dm_timeout;
  logic [1:0] state;
  logic [15:0] stall_cycles;
  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_used_d(rs1_used_d),
    .rs2_used_d(rs2_used_d), .rd_e(rd_e), .mem_read_e(mem_read_e),
    .branch_taken_e(branch_taken_e), .dm_req_m(dm_req_m), .dm_ready_m(dm_ready_m),
    .en_f(en_f), .en_d(en_d), .en_e(en_e), .en_m(en_m), .en_w(en_w),
    .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
    .dm_timeout(dm_timeout), .state(state), .stall_cycles(stall_cycles)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [4:0] rs1, rs2, rd;
    logic u1, u2, mr, br, req, rdy;
    logic [7:0] ctrl;
  } vec_t;
  typedef struct packed {
    logic [1:0] st;
    logic [7:0] ctrl;
  } exp_t;
  exp_t sb[$];
  vec_t vecs[9];
  int tests = 0, fails = 0, stall_m = 0;
  wire [7:0] ctrl = {en_f, en_d, en_e, en_m, en_w, flush_d, flush_e, flush_w};
  task automatic chk(input string n, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, req);
    end
  endtask
  task automatic drv(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                     input logic u1, input logic u2, input logic mr, input logic br,
                     input logic req, input logic rdy);
    rs1_d = r1; rs2_d = r2; rd_e = rd; rs1_used_d = u1; rs2_used_d = u2;
    mem_read_e = mr; branch_taken_e = br; dm_req_m = req; dm_ready_m = rdy;
  endtask
  task automatic step(input string n, input logic [7:0] c, input logic [1:0] s);
    exp_t e;
    sb.push_back('{st: s, ctrl: c});
    #2;
    e = sb.pop_front();
    chk({n, " ctrl"}, int'(ctrl), int'(e.ctrl));
    chk({n, " state"}, int'(state), int'(e.st));
    @(negedge clk);
    if (rst) stall_m = 0;
    else if (!e.ctrl[7] && e.st != 2'b10 && stall_m < 65535) stall_m++;
    chk({n, " stall"}, int'(stall_cycles), stall_m);
  endtask
  initial begin
    vecs = '{
      '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'b11111_000},
      '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'b00111_010},
      '{5'd1, 5'd7, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'b00111_010},
      '{5'd9, 5'd9, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'b11111_000},
      '{5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'b11111_000},
      '{5'd3, 5'd3, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'b11111_000},
      '{5'd2, 5'd4, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'b11111_110},
      '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'b11111_110},
      '{5'd8, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'b00111_010}
    };
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    step("reset", 8'b00000_111, 2'b00);
    chk("reset tmo", int'(dm_timeout), 0);
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drv(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].u1, vecs[i].u2,
          vecs[i].mr, vecs[i].br, vecs[i].req, vecs[i].rdy);
      step($sformatf("vec%0d", i), vecs[i].ctrl, 2'b00);
    end
    drv(0, 0, 0, 0, 0, 0, 1, 1, 0);
    step("wait1", 8'b00001_001, 2'b00);
    step("wait2", 8'b00001_001, 2'b01);
    step("wait3", 8'b00001_001, 2'b01);
    dm_ready_m = 1'b1;
    step("release", 8'b11111_110, 2'b01);
    chk("release state", int'(state), 0);
    chk("release tmo", int'(dm_timeout), 0);
    drv(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step("tmo1", 8'b00001_001, 2'b00);
    step("tmo2", 8'b00001_001, 2'b01);
    step("tmo3", 8'b00001_001, 2'b01);
    step("tmo4", 8'b00001_001, 2'b01);
    chk("halt tmo", int'(dm_timeout), 1);
    for (int i = 0; i < 3; i++) step("halt", 8'b00000_001, 2'b10);
    chk("halt tmo held", int'(dm_timeout), 1);
    rst = 1'b1;
    step("rst halt", 8'b00000_111, 2'b10);
    rst = 1'b0;
    chk("rst state", int'(state), 0);
    chk("rst tmo", int'(dm_timeout), 0);
    drv(5, 0, 5, 1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 70000; i++) step("sat", 8'b00111_010, 2'b00);
    chk("sat value", int'(stall_cycles), 16'hFFFF);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32 pipeline.
- Drives the enable and flush inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Resolves three conditions: load-use hazards, taken branch/jump redirects from EX, and multi-cycle data-memory accesses via a req/ready handshake.
- Includes a timeout watchdog and a stall-cycle performance counter.

Parameters:
- MEM_TIMEOUT, 15: consecutive not-ready memory cycles tolerated before HALT (legal range 1..2^CNT_W-1).
- CNT_W, 4: width of the internal wait counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- rs1_d  in  5  ID-stage rs1 index.
- rs2_d  in  5  ID-stage rs2 index.
- rs1_used_d  in  1  ID instruction reads rs1.
- rs2_used_d  in  1  ID instruction reads rs2.
- rd_e  in  5  EX-stage destination index.
- mem_read_e  in  1  EX instruction is a load.
- branch_taken_e  in  1  EX redirects the PC (taken branch, jal, jalr).
- dm_req_m  in  1  MEM instruction accesses data memory.
- dm_ready_m  in  1  data memory completes the access this cycle.
- en_f, en_d, en_e, en_m, en_w  out  1 each  register enables for PC, IF/ID, ID/EX, EX/MEM, MEM/WB.
- flush_d, flush_e, flush_w  out  1 each  load a NOP/zero into IF/ID, ID/EX, MEM/WB. Flush overrides enable at the register.
- dm_timeout  out  1  sticky watchdog error.
- state  out  2  FSM state: RUN=00, MEM_WAIT=01, HALT=10.
- stall_cycles  out  16  saturating count of stall cycles.

Behaviour:
- Reset (rst=1 at posedge):
  - state←RUN, wait_cnt←0, dm_timeout←0, stall_cycles←0.
  - While rst=1, outputs are combinationally forced: all en_*=0, flush_d=flush_e=flush_w=1.
- Combinational terms:
  - miss = dm_req_m & ~dm_ready_m.
  - lu = mem_read_e & (rd_e≠0) & ((rs1_used_d & rs1_d==rd_e) | (rs2_used_d & rs2_d==rd_e)).
- RUN, priority miss > branch > load-use > normal:
  - miss: en_f..en_m=0, en_w=1, flush_w=1 (bubble into WB), all other flushes 0. wait_cnt←1. If MEM_TIMEOUT==1 next HALT, else next MEM_WAIT.
  - branch_taken_e: all en=1, flush_d=1, flush_e=1. Any simultaneous lu is ignored; no stall.
  - lu: en_f=en_d=0, en_e=en_m=en_w=1, flush_e=1 (one bubble). Stays in RUN; a second lu cannot follow because the load has advanced.
  - otherwise: all en=1, all flush=0.
- MEM_WAIT:
  - dm_ready_m=1 or dm_req_m=0: outputs as RUN-normal, except branch/lu are evaluated exactly as in RUN. Next state RUN, wait_cnt←0.
  - miss and wait_cnt+1==MEM_TIMEOUT: freeze outputs as for miss, next HALT, dm_timeout←1.
  - miss otherwise: freeze as for miss, wait_cnt←wait_cnt+1.
  - branch_taken_e is ignored while frozen. EX is held, so the redirect is re-seen on release.
- HALT:
  - All en=0, flush_w=1, dm_timeout=1.
  - Exits only via rst.
- stall_cycles:
  - Increments at each posedge where en_f==0, state≠HALT and rst=0.
  - Saturates at 16'hFFFF; no wrap.
- Latency:
  - All control outputs are combinational from current inputs and state (same cycle).
  - Only state, wait_cnt, dm_timeout and stall_cycles are registered.
- Reset mid-MEM_WAIT or in HALT: returns to RUN on the next edge and clears everything.

Test Plan:
- Load-use: mem_read_e=1, rd_e=5, rs1_d=5, rs1_used_d=1 for one cycle → en_f=en_d=0, flush_e=1 that cycle; stall_cycles 0→1; state stays 00.
- rd_e=0 with a matching x0 source and mem_read_e=1 → no stall: all en=1, flush_e=0.
- Branch plus load-use in the same cycle: branch_taken_e=1 and lu true → flush_d=flush_e=1, en_f=1, no stall; stall_cycles unchanged.
- Memory wait: dm_req_m=1, dm_ready_m=0 for 3 cycles then ready=1 → en_f..en_m=0 and flush_w=1 for 3 cycles, state=01 on cycles 2–3, release on cycle 4, stall_cycles=3, dm_timeout=0.
- Timeout (MEM_TIMEOUT=4): dm_ready_m held 0 → HALT (state=10) and dm_timeout=1 after the 4th edge. Outputs stay frozen indefinitely; rst=1 for one cycle restores state=00 and dm_timeout=0.
- Saturation: force 70000 stall cycles (continuous lu stimulus) → stall_cycles reads 16'hFFFF and holds.
